// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives the sample switch and the DAC trial code,
// and resolves one bit per settle window from the synchronised comparator decision.
module sar_adc_ctrl #(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cmp_in,
    output logic         sample,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int BW   = $clog2(N);
    localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [BW-1:0] MSB_IDX     = BW'(N - 1);
    localparam logic [BW-1:0] BIT_ONE     = BW'(1);
    localparam logic [N-1:0]  MSB_ONE     = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  LSB_ONE     = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [BW-1:0] bit_r, bit_s;
    logic          sync1_r, sync2_r;
    logic          sample_r, sample_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic [N-1:0]  dac_r, dac_s;
    logic [N-1:0]  result_r, result_s;
    logic          cmp_s;
    logic [N-1:0]  bit_mask_s;
    logic [N-1:0]  decided_s;

    assign cmp_s      = sync2_r;
    assign bit_mask_s = LSB_ONE << bit_r;
    // The trial bit survives only when the held input is at or above the DAC level.
    assign decided_s  = cmp_s ? dac_r : (dac_r & ~bit_mask_s);

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= cmp_in;
            sync2_r <= sync1_r;
        end
    end

    // Next-state and registered-output computation for the conversion sequencer.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        bit_s    = bit_r;
        sample_s = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        dac_s    = '0;
        result_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_SAMPLE;
                    cnt_s    = '0;
                    sample_s = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                busy_s = 1'b1;
                if (cnt_r == SAMPLE_LAST) begin
                    state_s = ST_CONVERT;
                    cnt_s   = '0;
                    bit_s   = MSB_IDX;
                    dac_s   = MSB_ONE;
                end else begin
                    cnt_s    = cnt_r + CNT_ONE;
                    sample_s = 1'b1;
                end
            end
            ST_CONVERT: begin
                busy_s = 1'b1;
                dac_s  = dac_r;
                if (cnt_r == SETTLE_LAST) begin
                    cnt_s = '0;
                    if (bit_r == '0) begin
                        // Last bit resolved: publish and fall straight back to idle.
                        state_s  = ST_IDLE;
                        result_s = decided_s;
                        done_s   = 1'b1;
                        busy_s   = 1'b0;
                        dac_s    = '0;
                    end else begin
                        bit_s = bit_r - BIT_ONE;
                        dac_s = decided_s | (bit_mask_s >> 1);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                bit_s   = '0;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            bit_r    <= '0;
            sample_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dac_r    <= '0;
            result_r <= '0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            bit_r    <= bit_s;
            sample_r <= sample_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            dac_r    <= dac_s;
            result_r <= result_s;
        end
    end

    assign sample   = sample_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign dac_code = dac_r;
    assign result   = result_r;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: a default instance and a small N=4 instance, each
// compared every cycle against a phase-based conversion model, plus directed literal checks.
module tb_sar_adc_ctrl;
    localparam int N0 = 8, S0 = 4, T0 = 2, L0 = S0 + N0 * T0;
    localparam int N1 = 4, S1 = 1, T1 = 3, L1 = S1 + N1 * T1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic       cmp0, cmp1;
    logic       sample0, busy0, done0;
    logic [7:0] dac0, res0;
    logic       sample1, busy1, done1;
    logic [3:0] dac1, res1;

    int vin0, vin1;
    int ph0 = -1, ph1 = -1;   // -1 idle, 0..L-1 converting, L done cycle
    int mres0 = 0, mres1 = 0;
    int cyc = 0;
    int n_pass = 0, n_tot = 0;
    int lat;
    int codes_q[$];
    int exp_q[$];
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sar_adc_ctrl #(.N(N0), .SAMPLE_CYCLES(S0), .SETTLE_CYCLES(T0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cmp_in(cmp0), .sample(sample0),
        .dac_code(dac0), .busy(busy0), .done(done0), .result(res0)
    );

    sar_adc_ctrl #(.N(N1), .SAMPLE_CYCLES(S1), .SETTLE_CYCLES(T1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cmp_in(cmp1), .sample(sample1),
        .dac_code(dac1), .busy(busy1), .done(done1), .result(res1)
    );

    // Ideal SAR trial code at phase ph: bits above k taken from vin, bit k set, rest clear.
    function automatic int trial(input int ph, input int vin, input int n, input int s, input int t);
        int k;
        if (ph < s || ph >= s + n * t) return 0;
        k = n - 1 - (ph - s) / t;
        return (vin & ~((1 << (k + 1)) - 1)) | (1 << k);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, got, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Conversion model: a phase count from the accepting edge; result equals vin at the done edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            ph0 <= -1; mres0 <= 0; ph1 <= -1; mres1 <= 0;
        end else begin
            if (ph0 < 0 || ph0 == L0) ph0 <= start0 ? 0 : -1;
            else begin
                ph0 <= ph0 + 1;
                if (ph0 + 1 == L0) mres0 <= vin0;
            end
            if (ph1 < 0 || ph1 == L1) ph1 <= start1 ? 0 : -1;
            else begin
                ph1 <= ph1 + 1;
                if (ph1 + 1 == L1) mres1 <= vin1;
            end
        end
    end

    // Comparator model, presented ahead by the synchroniser depth so each decision sees its own trial code.
    always @(negedge clk) begin
        cmp0 = (ph0 < 0) ? 1'b1 : (vin0 >= trial(ph0 + 2, vin0, N0, S0, T0));
        cmp1 = (ph1 < 0) ? 1'b1 : (vin1 >= trial(ph1 + 2, vin1, N1, S1, T1));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sample0", 32'(sample0), 32'(ph0 >= 0 && ph0 < S0));
            chk("busy0",   32'(busy0),   32'(ph0 >= 0 && ph0 < L0));
            chk("done0",   32'(done0),   32'(ph0 == L0));
            chk("dac0",    32'(dac0),    32'(trial(ph0, vin0, N0, S0, T0)));
            chk("result0", 32'(res0),    32'(mres0));
            chk("sample1", 32'(sample1), 32'(ph1 >= 0 && ph1 < S1));
            chk("busy1",   32'(busy1),   32'(ph1 >= 0 && ph1 < L1));
            chk("done1",   32'(done1),   32'(ph1 == L1));
            chk("dac1",    32'(dac1),    32'(trial(ph1, vin1, N1, S1, T1)));
            chk("result1", 32'(res1),    32'(mres1));
        end
    end

    // One conversion on the selected instance; records latency and the distinct trial codes.
    task automatic run(input int which, input int v);
        int e0, last, d;
        codes_q = {};
        lat = -1;
        last = 0;
        if (which == 0) vin0 = v; else vin1 = v;
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        e0 = cyc;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            d = (which == 0) ? int'(dac0) : int'(dac1);
            if (d != 0 && d != last) codes_q.push_back(d);
            last = d;
            if ((which == 0) ? done0 : done1) begin
                lat = cyc - e0;
                break;
            end
        end
    endtask

    task automatic check_codes(input string nm);
        chk({nm, "_count"}, 32'(codes_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < codes_q.size()) chk(nm, 32'(codes_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0, nd, dd[3], lastlat;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; vin0 = 0; vin1 = 0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 'hA5);
        chk("lat_a5", 32'(lat), 32'd20);
        chk("res_a5", 32'(res0), 32'h0000_00A5);
        exp_q = '{'h80, 'hC0, 'hA0, 'hB0, 'hA8, 'hA4, 'hA6, 'hA5};
        check_codes("codes_a5");
        repeat (3) @(negedge clk);

        run(0, 'h00);
        chk("lat_00", 32'(lat), 32'd20);
        chk("res_00", 32'(res0), 32'h0000_0000);
        exp_q = '{'h80, 'h40, 'h20, 'h10, 'h08, 'h04, 'h02, 'h01};
        check_codes("codes_00");
        repeat (2) @(negedge clk);

        run(0, 'hFF);
        chk("lat_ff", 32'(lat), 32'd20);
        chk("res_ff", 32'(res0), 32'h0000_00FF);
        repeat (2) @(negedge clk);

        // start held high: back-to-back conversions
        vin0 = 'h3C;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        e0 = cyc; nd = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done0) begin
                dd[nd] = cyc - e0;
                chk("res_3c", 32'(res0), 32'h0000_003C);
                nd++;
                if (nd == 3) begin
                    start0 = 1'b0;
                    break;
                end
            end
        end
        chk("b2b_count", 32'(nd), 32'd3);
        chk("b2b_done1", 32'(dd[0]), 32'd20);
        chk("b2b_done2", 32'(dd[1]), 32'd41);
        chk("b2b_done3", 32'(dd[2]), 32'd62);
        start0 = 1'b0;
        repeat (3) @(negedge clk);

        // start pulse at edge 7 of a running conversion is ignored
        vin0 = 'hA5;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        e0 = cyc;
        repeat (6) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        nd = 0; lastlat = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done0) begin
                nd++;
                lastlat = cyc - e0;
            end
        end
        chk("ign_count", 32'(nd), 32'd1);
        chk("ign_lat", 32'(lastlat), 32'd20);

        // reset at edge 10 of a conversion
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        e0 = cyc;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_result", 32'(res0), 32'h0);
        chk("rst_busy",   32'(busy0), 32'h0);
        chk("rst_sample", 32'(sample0), 32'h0);
        chk("rst_dac",    32'(dac0), 32'h0);
        chk("rst_done",   32'(done0), 32'h0);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done0) nd++;
        end
        chk("rst_no_done", 32'(nd), 32'd0);
        run(0, 'h5A);
        chk("lat_5a", 32'(lat), 32'd20);
        chk("res_5a", 32'(res0), 32'h0000_005A);
        repeat (2) @(negedge clk);

        // N=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=3
        run(1, 'h9);
        chk("lat_n4", 32'(lat), 32'd13);
        chk("res_n4", 32'(res1), 32'h0000_0009);
        exp_q = '{'h8, 'hC, 'hA, 'h9};
        check_codes("codes_n4");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
